// File: rtl/demux_1to4_32.sv
// ============================================================================
// demux_1to4_32 : 1-to-4 valid/ready demultiplexer with four one-entry slots
// Rev 1.0
// ============================================================================
`default_nettype none

module demux_1to4_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [15:0]      xfer_cnt
);

  localparam int c_SLOTS = 4;

  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [WIDTH-1:0] data_q [c_SLOTS];
  logic [WIDTH-1:0] data_d [c_SLOTS];
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;

  logic             w_accept;
  logic [3:0]       w_load;

  // A full slot can still take a word when its sink drains it in the same cycle.
  assign in_ready = rst_n & (~valid_q[in_sel] | out_ready[in_sel]);
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = 4'b0000;
    if (w_accept) begin
      w_load[in_sel] = 1'b1;
    end
  end

  generate
    for (genvar i = 0; i < c_SLOTS; i++) begin : g_slot
      always_comb begin
        valid_d[i] = valid_q[i];
        data_d[i]  = data_q[i];
        if (valid_q[i] && out_ready[i]) begin
          valid_d[i] = 1'b0;
        end
        if (w_load[i]) begin
          valid_d[i] = 1'b1;
          data_d[i]  = in_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q[i] <= 1'b0;
          data_q[i]  <= '0;
        end else begin
          valid_q[i] <= valid_d[i];
          data_q[i]  <= data_d[i];
        end
      end
    end
  endgenerate

  assign cnt_d = w_accept ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign xfer_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: doc/demux_1to4_32.md
DEMUX_1TO4_32 -- requirements
Module: demux_1to4_32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of the input and each output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the source offers a word.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-006 The block SHALL have port in_sel, input, 2 bits: destination index 0..3 of the offered word.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: the offered word.
REQ-008 The block SHALL have port out_valid, output, 4 bits: bit i means slot i holds a word.
REQ-009 The block SHALL have port out_ready, input, 4 bits: bit i means sink i takes slot i this cycle.
REQ-010 The block SHALL have ports out_data0, out_data1, out_data2 and out_data3, outputs, WIDTH bits each: contents of slots 0..3.
REQ-011 The block SHALL have port xfer_cnt, output, 16 bits: count of accepted input words.

Function
REQ-012 The block SHALL contain four independent one-entry slots, each with state EMPTY (out_valid[i]=0) or FULL (out_valid[i]=1).
REQ-013 The block SHALL drive in_ready combinationally as (slot[in_sel] EMPTY) OR out_ready[in_sel], forced to 0 while rst_n is low.
REQ-014 An input accept SHALL occur in a cycle where in_valid=1 and in_ready=1.
REQ-015 On accept, at the next rising edge, slot[in_sel] SHALL load in_data and go FULL, giving one-cycle latency from accept to out_valid.
REQ-016 A drain of slot i SHALL occur in a cycle where out_valid[i]=1 and out_ready[i]=1; at the next edge slot i goes EMPTY unless REQ-017 applies.
REQ-017 On a simultaneous drain and accept to the same slot, the slot SHALL load the new word and remain FULL, sustaining one word per cycle.
REQ-018 Drains on several slots in the same cycle SHALL all complete, and an accept to one slot SHALL NOT affect any other slot.
REQ-019 The block SHALL hold out_dataN stable while out_valid[N]=1 and out_ready[N]=0.
REQ-020 When slot N goes EMPTY, out_dataN SHALL retain its last value.
REQ-021 The block SHALL ignore in_sel and in_data while in_valid=0, and SHALL NOT raise any out_valid without an accept.
REQ-022 The block SHALL ignore out_ready[i] while slot i is EMPTY, with no state change.
REQ-023 xfer_cnt SHALL increment by 1 at each edge following an accept and wrap from 0xFFFF to 0x0000.
REQ-024 With in_valid held high to a FULL slot whose out_ready is low, the block SHALL keep in_ready at 0 and change no state, stalling the source.

Reset
REQ-025 Asserting rst_n low SHALL immediately and asynchronously clear out_valid to 4'b0000, out_data0..3 to 0 and xfer_cnt to 0.
REQ-026 Reset asserted mid-operation SHALL discard all slot contents; no drain or accept SHALL be recognised while rst_n is low.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept a word, since in_ready=1 with all slots EMPTY.

Verification
REQ-028 Single route: in_sel=2, in_data=0xDEADBEEF, in_valid for 1 cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=0xDEADBEEF, xfer_cnt=1.
REQ-029 Backpressure: slot 1 FULL with 0x11, out_ready[1]=0, offer 0x22 to sel=1 -> in_ready=0 and out_data1 stays 0x11; raise out_ready[1] -> that cycle in_ready=1 and next cycle out_data1=0x22.
REQ-030 Streaming: 8 consecutive words 1..8 to sel=0 with out_ready[0]=1 held -> in_ready stays 1 and sink 0 receives 1..8 on consecutive cycles.
REQ-031 Parallel drain: slots 0 and 3 FULL, out_ready=4'b1001 for one cycle -> out_valid=4'b0000 next cycle, data outputs unchanged.
REQ-032 Counter wrap: preload by 65535 accepts, one more accept -> xfer_cnt=0x0000.
REQ-033 Mid-operation reset: all four slots FULL, rst_n pulsed low between edges -> outputs zero immediately; after release, one accept to sel=3 gives out_valid=4'b1000.
